// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share one fifo_flops write port in bursts.
// Latency: grant is taken one cycle after a request is seen in IDLE; then one word per cycle.
// Backpressure: fifo_full deasserts the owner's req_ready and stalls the burst without losing it.
module fifo_push_arbiter #(
  parameter int N_REQ     = 4,
  parameter int BITS      = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [N_REQ-1:0]                                 req_valid,
  input  logic [N_REQ*BITS-1:0]                            req_data,
  output logic [N_REQ-1:0]                                 req_ready,
  output logic [BITS-1:0]                                  fifo_din,
  output logic                                             fifo_push,
  input  logic                                             fifo_full,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0]    grant_id,
  output logic                                             busy,
  output logic [15:0]                                      push_count
);

  // Index width stays at least one bit so a single-requester build still elaborates.
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // Burst counter only needs to reach MAX_BURST.
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [15:0]        push_count_q, push_count_d;

  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  int                 cand;
  logic               owner_vld;
  logic               xfer;
  logic               last_beat;
  logic [IDX_W-1:0]   next_ptr;

  // Find the first valid requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      if (!pick_vld && req_valid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(cand);
      end
    end
  end

  // Owner-side qualifiers shared by the FSM and the output decode.
  always_comb begin
    owner_vld = req_valid[owner_q];
    xfer      = !rst && (state_q == BURST) && owner_vld && !fifo_full;
    last_beat = (burst_cnt_q == CNT_W'(MAX_BURST - 1));
    next_ptr  = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
  end

  // Next-state logic: grant in IDLE, count transfers in BURST, release on limit or dropped valid.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    burst_cnt_d  = burst_cnt_q;
    push_count_d = push_count_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d     = BURST;
          owner_d     = pick_idx;
          burst_cnt_d = '0;
        end
      end
      BURST: begin
        if (!owner_vld) begin
          // Owner has nothing left: hand the port to the next requester in rotation.
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end else if (!fifo_full) begin
          burst_cnt_d  = burst_cnt_q + 1'b1;
          push_count_d = push_count_q + 16'd1;
          if (last_beat) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end
        end
        // fifo_full with a valid owner: hold everything and wait.
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset; arbitration restarts from index 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      burst_cnt_q  <= '0;
      push_count_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      burst_cnt_q  <= burst_cnt_d;
      push_count_q <= push_count_d;
    end
  end

  // Output decode; everything is forced to zero while rst is high, even before the state clears.
  always_comb begin
    req_ready  = '0;
    fifo_din   = '0;
    fifo_push  = 1'b0;
    grant_id   = '0;
    busy       = 1'b0;
    push_count = rst ? 16'd0 : push_count_q;
    if (!rst && (state_q == BURST)) begin
      busy               = 1'b1;
      grant_id           = owner_q;
      req_ready[owner_q] = !fifo_full;
      if (xfer) begin
        fifo_push = 1'b1;
        fifo_din  = req_data[int'(owner_q)*BITS +: BITS];
      end
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter: directed scenarios plus random traffic against a behavioural model.
// A second instance with a long burst limit streams 65537 words to exercise counter wrap.
// Outputs are sampled mid-cycle, well away from the rising edge.
module tb_fifo_push_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int MB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance.
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic [W-1:0]     fifo_din;
  logic             fifo_push;
  logic             fifo_full;
  logic [1:0]       grant_id;
  logic             busy;
  logic [15:0]      push_count;

  // Wrap instance.
  logic             w_rst;
  logic [N-1:0]     w_valid;
  logic [N*W-1:0]   w_data;
  logic [N-1:0]     w_ready;
  logic [W-1:0]     w_din;
  logic             w_push;
  logic             w_full;
  logic [1:0]       w_grant;
  logic             w_busy;
  logic [15:0]      w_count;

  fifo_push_arbiter #(.N_REQ(N), .BITS(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_din(fifo_din), .fifo_push(fifo_push),
    .fifo_full(fifo_full), .grant_id(grant_id), .busy(busy), .push_count(push_count)
  );

  fifo_push_arbiter #(.N_REQ(N), .BITS(W), .MAX_BURST(1024)) dut_wrap (
    .clk(clk), .rst(w_rst), .req_valid(w_valid), .req_data(w_data),
    .req_ready(w_ready), .fifo_din(w_din), .fifo_push(w_push),
    .fifo_full(w_full), .grant_id(w_grant), .busy(w_busy), .push_count(w_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_checks++;
    if (obs !== req) begin
      n_errors++;
      $display("FAIL %s: observed %0h required %0h", tag, obs, req);
    end
  endtask

  // Behavioural model: who holds the port, how many words it has moved, whose turn is next.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_done  = 0;
  int m_rr    = 0;
  int m_total = 0;

  // Values seen in the most recent cycle, for directed scenario checks.
  logic        last_push;
  logic [1:0]  last_grant;
  logic        last_busy;
  logic        last_ready;
  logic [15:0] last_count;

  // One clock cycle: drive inputs, compare all outputs to the model, then advance the model.
  task automatic cyc(input logic r, input logic [N-1:0] v, input logic f);
    logic [N-1:0] e_ready;
    logic         e_push;
    logic [W-1:0] e_din;
    int           e_grant;
    logic         e_busy;
    int           found;
    int           idx;
    rst       = r;
    req_valid = v;
    fifo_full = f;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = $urandom;
    #1;
    e_ready = '0; e_push = 1'b0; e_din = '0; e_grant = 0; e_busy = 1'b0;
    if (!r && m_busy) begin
      e_busy  = 1'b1;
      e_grant = m_owner;
      if (!f) e_ready[m_owner] = 1'b1;
      if (v[m_owner] && !f) begin
        e_push = 1'b1;
        e_din  = req_data[m_owner*W +: W];
      end
    end
    chk("req_ready", req_ready, e_ready);
    chk("fifo_push", fifo_push, e_push);
    chk("fifo_din", fifo_din, e_din);
    chk("grant_id", grant_id, e_grant);
    chk("busy", busy, e_busy);
    chk("push_count", push_count, r ? 0 : (m_total % 65536));
    last_push  = fifo_push;
    last_grant = grant_id;
    last_busy  = busy;
    last_ready = |req_ready;
    last_count = push_count;
    @(posedge clk);
    if (r) begin
      m_busy = 1'b0; m_owner = 0; m_done = 0; m_rr = 0; m_total = 0;
    end else if (!m_busy) begin
      found = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (found < 0 && v[idx]) found = idx;
      end
      if (found >= 0) begin
        m_busy = 1'b1; m_owner = found; m_done = 0;
      end
    end else if (!v[m_owner]) begin
      m_busy = 1'b0; m_rr = (m_owner + 1) % N;
    end else if (!f) begin
      m_done++;
      m_total++;
      if (m_done == MB) begin
        m_busy = 1'b0; m_rr = (m_owner + 1) % N;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b1, '0, 1'b0);
    cyc(1'b1, '0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; fifo_full = 1'b0;
    w_rst = 1'b1; w_valid = '0; w_data = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    w_full = 1'b0;
    fork
      // Main instance: directed scenarios then random traffic.
      begin
        int          words;
        logic [11:0] hist12;
        logic [8:0]  hist_p, hist_b, hist_r;
        int          gq[$];

        // Single requester, six words.
        do_reset();
        words = 6; hist12 = '0;
        for (int c = 0; c < 12; c++) begin
          cyc(1'b0, (words > 0) ? 4'b0010 : 4'b0000, 1'b0);
          if (c == 1) chk("s1_grant", last_grant, 1);
          hist12 = {hist12[10:0], last_push};
          if (last_push) words--;
        end
        chk("s1_push_pattern", hist12, 12'b0111_1011_0000);
        chk("s1_push_count", push_count, 6);

        // Round robin with everyone requesting.
        do_reset();
        for (int c = 0; c < 25; c++) begin
          cyc(1'b0, 4'b1111, 1'b0);
          if (last_push) gq.push_back(int'(last_grant));
        end
        chk("s2_num_pushes", gq.size(), 20);
        for (int k = 0; k < gq.size() && k < 20; k++) chk("s2_grant_order", gq[k], (k / 4) % 4);

        // Full stall in the middle of a burst.
        do_reset();
        hist_p = '0; hist_b = '0; hist_r = '0;
        for (int c = 0; c < 9; c++) begin
          cyc(1'b0, 4'b0001, (c >= 3 && c <= 5));
          hist_p = {hist_p[7:0], last_push};
          hist_b = {hist_b[7:0], last_busy};
          hist_r = {hist_r[7:0], last_ready};
        end
        chk("s3_push_pattern", hist_p, 9'b011000110);
        chk("s3_busy_pattern", hist_b, 9'b011111110);
        chk("s3_ready_pattern", hist_r, 9'b011000110);

        // Early release by owner 2, requester 3 pending.
        do_reset();
        cyc(1'b0, 4'b0100, 1'b0);
        cyc(1'b0, 4'b0100, 1'b0);
        chk("s4a_owner2_push", {last_grant, last_push}, {2'd2, 1'b1});
        cyc(1'b0, 4'b1001, 1'b0);
        chk("s4a_release_nopush", last_push, 1'b0);
        cyc(1'b0, 4'b1001, 1'b0);
        cyc(1'b0, 4'b1001, 1'b0);
        chk("s4a_next_grant", last_grant, 3);

        // Early release by owner 2, only requester 0 pending.
        do_reset();
        cyc(1'b0, 4'b0100, 1'b0);
        cyc(1'b0, 4'b0100, 1'b0);
        cyc(1'b0, 4'b0001, 1'b0);
        cyc(1'b0, 4'b0001, 1'b0);
        cyc(1'b0, 4'b0001, 1'b0);
        chk("s4b_next_grant", {last_busy, last_grant}, {1'b1, 2'd0});

        // Reset during owner 3's second push cycle.
        do_reset();
        cyc(1'b0, 4'b1000, 1'b0);
        cyc(1'b0, 4'b1000, 1'b0);
        chk("s5_first_push", {last_grant, last_push}, {2'd3, 1'b1});
        cyc(1'b1, 4'b1000, 1'b0);
        chk("s5_rst_push", last_push, 1'b0);
        chk("s5_rst_grant", last_grant, 0);
        chk("s5_rst_count", last_count, 0);
        cyc(1'b0, 4'b1001, 1'b0);
        chk("s5_after_count", last_count, 0);
        cyc(1'b0, 4'b1001, 1'b0);
        chk("s5_restart_grant", {last_busy, last_grant, last_push}, {1'b1, 2'd0, 1'b1});

        // Random traffic.
        do_reset();
        for (int c = 0; c < 800; c++) begin
          logic [N-1:0] v;
          for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 9) < 7);
          cyc(($urandom_range(0, 99) < 2), v, ($urandom_range(0, 3) == 0));
        end
      end
      // Wrap instance: stream 65537 words through and check the counter wrapped to 1.
      begin
        int  cnt;
        int  ncyc;
        bit  saw_zero;
        cnt = 0; ncyc = 0; saw_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        w_rst   = 1'b0;
        w_valid = 4'b1111;
        while (cnt < 65537 && ncyc < 70000) begin
          #1;
          if (w_push) cnt++;
          ncyc++;
          @(posedge clk);
          #1;
          if (cnt == 65536 && !saw_zero) begin
            saw_zero = 1'b1;
            chk("wrap_count_at_65536", w_count, 0);
          end
        end
        w_valid = '0;
        chk("wrap_transfers", cnt, 65537);
        chk("wrap_count", w_count, 1);
      end
    join
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_push_arbiter.md
FIFO_PUSH_ARBITER -- requirements
Module: fifo_push_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one fifo_flops write port.
REQ-002 Parameter BITS, default 32, data width; matches the fifo_flops bits parameter.
REQ-003 Parameter MAX_BURST, default 4, maximum consecutive pushes per grant (at least 1).
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  N_REQ  bit i: requester i has a word to push.
REQ-007 req_data  input  N_REQ*BITS  requester i word in bits [i*BITS +: BITS].
REQ-008 req_ready  output  N_REQ  bit i: requester i word accepted this cycle.
REQ-009 fifo_din  output  BITS  data to the fifo Din.
REQ-010 fifo_push  output  1  one-cycle write strobe to the fifo push.
REQ-011 fifo_full  input  1  fifo full flag.
REQ-012 grant_id  output  $clog2(N_REQ)  index of the current owner; 0 when idle.
REQ-013 busy  output  1  high while in BURST.
REQ-014 push_count  output  16  total accepted words; wraps modulo 2^16.

Function
REQ-015 The FSM SHALL have two states: IDLE and BURST.
REQ-016 In IDLE with any req_valid high, the block SHALL select the first valid index at or after rr_ptr, searching upward modulo N_REQ. It SHALL latch that index as owner, clear burst_cnt and enter BURST on the next edge.
REQ-017 In IDLE, req_ready, fifo_push and busy SHALL be 0; no data transfers in IDLE.
REQ-018 In BURST, req_ready[owner] SHALL equal !fifo_full combinationally; all other req_ready bits SHALL be 0.
REQ-019 A transfer occurs when state is BURST, req_valid[owner]=1 and fifo_full=0. In that cycle fifo_push SHALL be 1 and fifo_din SHALL equal the owner's req_data slice.
REQ-020 fifo_push SHALL be 0 in every non-transfer cycle; fifo_din SHALL be 0 when fifo_push is 0.
REQ-021 Each transfer SHALL increment burst_cnt and push_count by 1.
REQ-022 BURST SHALL return to IDLE after the transfer that makes burst_cnt equal MAX_BURST.
REQ-023 BURST SHALL also return to IDLE on any BURST cycle where req_valid[owner]=0.
REQ-024 fifo_full=1 with req_valid[owner]=1 SHALL stall: remain in BURST, no transfer, burst_cnt held.
REQ-025 On every BURST-to-IDLE exit, rr_ptr SHALL become (owner+1) mod N_REQ.
REQ-026 The first transfer of a grant SHALL occur no earlier than one cycle after req_valid rises in IDLE.
REQ-027 Every later transfer of the same burst MAY occur on consecutive cycles.
REQ-028 Requests arriving from non-owners during BURST SHALL not alter the owner or rr_ptr.
REQ-029 grant_id SHALL equal owner in BURST and 0 in IDLE.

Reset
REQ-030 With rst=1 at an edge, the block SHALL set state=IDLE, rr_ptr=0, owner=0, burst_cnt=0 and push_count=0.
REQ-031 While rst=1, all outputs SHALL be 0.
REQ-032 rst asserted mid-burst SHALL abort the burst with no push in the reset cycle.
REQ-033 After rst deasserts, arbitration SHALL restart from index 0.

Verification
REQ-034 Single requester: req_valid=4'b0010 held with 6 words, fifo_full=0 -> grant_id=1, then 4 consecutive pushes, 1 IDLE cycle, then 2 more pushes; push_count=6.
REQ-035 Round robin: req_valid=4'b1111 held, MAX_BURST=4 -> bursts of 4 pushes granted in order 0,1,2,3,0.
REQ-036 Full stall: mid-burst fifo_full=1 for 3 cycles -> fifo_push=0 and req_ready=0 for those cycles, still in BURST; burst resumes with the remaining count after fifo_full=0.
REQ-037 Early release: owner 2 drops req_valid after 1 push -> IDLE, rr_ptr=3; pending requester 0 is granted after requester 3 if 3 is valid, else 0 is granted.
REQ-038 Reset mid-burst: rst=1 during owner 3's second push cycle -> no push, push_count=0, grant_id=0; with req_valid=4'b1001 after reset, requester 0 is granted first.
REQ-039 Wrap: 65537 transfers -> push_count=1.
